// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared definitions for the IF/ID/EX hold/flush sequencer.
// Provides the FSM state encodings, the x0 register constant, default bus
// widths and the per-register hold/flush control bundle with its canned values.
package pipe_hold_ctrl_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned ADDR_W_DEF     = 32;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_DIV_WAIT = 1'b1;

  // Architectural zero register: writes to it never create a hazard.
  localparam logic [REG_ADDR_W_DEF-1:0] ZERO_REG = '0;

  // Hold/flush request bundle for PC, IF/ID and ID/EX.
  typedef struct packed {
    logic hold_pc;
    logic hold_ifid;
    logic hold_idex;
    logic flush_ifid;
    logic flush_idex;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_NONE = '{hold_pc: 1'b0, hold_ifid: 1'b0, hold_idex: 1'b0,
                                       flush_ifid: 1'b0, flush_idex: 1'b0};
  // Freeze the whole front end (divide in flight).
  localparam pipe_ctrl_t CTRL_HOLD_ALL = '{hold_pc: 1'b1, hold_ifid: 1'b1, hold_idex: 1'b1,
                                           flush_ifid: 1'b0, flush_idex: 1'b0};
  // Squash both younger stages (redirect).
  localparam pipe_ctrl_t CTRL_FLUSH_ALL = '{hold_pc: 1'b0, hold_ifid: 1'b0, hold_idex: 1'b0,
                                            flush_ifid: 1'b1, flush_idex: 1'b1};
  // Load-use bubble: keep PC and IF/ID, insert a NOP into ID/EX.
  localparam pipe_ctrl_t CTRL_BUBBLE = '{hold_pc: 1'b1, hold_ifid: 1'b1, hold_idex: 1'b0,
                                         flush_ifid: 1'b0, flush_idex: 1'b1};
  // Divide watchdog abort: release holds and drop the stuck EX slot.
  localparam pipe_ctrl_t CTRL_WDOG = '{hold_pc: 1'b0, hold_ifid: 1'b0, hold_idex: 1'b0,
                                       flush_ifid: 1'b0, flush_idex: 1'b1};

endpackage

// File: rtl/pipe_hold_ctrl_load_use_detect.sv
// Combinational load-use hazard detector.
// Ports: ID source addresses/read enables, EX destination/write enable/load
// flag in; load_use_c out (1 when the ID instruction needs the EX load result).
module pipe_hold_ctrl_load_use_detect
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] id_reg1_raddr,
  input  logic [REG_ADDR_W-1:0] id_reg2_raddr,
  input  logic                  id_reg1_re,
  input  logic                  id_reg2_re,
  input  logic [REG_ADDR_W-1:0] ex_reg_waddr,
  input  logic                  ex_reg_we,
  input  logic                  ex_is_load,
  output logic                  load_use_c
);

  logic rs1_hit_c;
  logic rs2_hit_c;
  logic ex_writes_c;

  assign rs1_hit_c   = id_reg1_re && (id_reg1_raddr == ex_reg_waddr);
  assign rs2_hit_c   = id_reg2_re && (id_reg2_raddr == ex_reg_waddr);
  // x0 is hardwired, so a load targeting it never produces a hazard.
  assign ex_writes_c = ex_is_load && ex_reg_we && (ex_reg_waddr != REG_ADDR_W'(ZERO_REG));
  assign load_use_c  = ex_writes_c && (rs1_hit_c || rs2_hit_c);

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Central hold/flush sequencer for the IF/ID/EX pipeline.
// Inputs: ID/EX hazard info, divider start/ready, EX jump, interrupt request.
// Outputs (combinational, zero latency): PC/IF-ID/ID-EX holds, IF-ID/ID-EX
// flushes, PC redirect flag/address, divide watchdog error pulse.
module pipe_hold_ctrl
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DIV_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_reg1_raddr_i,
  input  logic [REG_ADDR_W-1:0] id_reg2_raddr_i,
  input  logic                  id_reg1_re_i,
  input  logic                  id_reg2_re_i,
  input  logic [REG_ADDR_W-1:0] ex_reg_waddr_i,
  input  logic                  ex_reg_we_i,
  input  logic                  ex_is_load_i,
  input  logic                  ex_div_start_i,
  input  logic                  div_ready_i,
  input  logic                  ex_jump_flag_i,
  input  logic [ADDR_W-1:0]     ex_jump_addr_i,
  input  logic                  int_assert_i,
  input  logic [ADDR_W-1:0]     int_addr_i,
  output logic                  hold_pc_o,
  output logic                  hold_ifid_o,
  output logic                  hold_idex_o,
  output logic                  flush_ifid_o,
  output logic                  flush_idex_o,
  output logic                  jump_flag_o,
  output logic [ADDR_W-1:0]     jump_addr_o,
  output logic                  div_err_o
);

  logic [0:0]        state_q, state_d;
  logic              int_pend_q, int_pend_d;
  logic [ADDR_W-1:0] int_addr_q, int_addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              load_use_c;
  pipe_ctrl_t        ctrl_c;
  logic              jump_flag_c;
  logic [ADDR_W-1:0] jump_addr_c;
  logic              div_err_c;

  pipe_hold_ctrl_load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .id_reg1_raddr (id_reg1_raddr_i),
    .id_reg2_raddr (id_reg2_raddr_i),
    .id_reg1_re    (id_reg1_re_i),
    .id_reg2_re    (id_reg2_re_i),
    .ex_reg_waddr  (ex_reg_waddr_i),
    .ex_reg_we     (ex_reg_we_i),
    .ex_is_load    (ex_is_load_i),
    .load_use_c    (load_use_c)
  );

  // State, interrupt latch and divide watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      int_pend_q <= 1'b0;
      int_addr_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      int_pend_q <= int_pend_d;
      int_addr_q <= int_addr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state and control decode; everything stays quiet while in reset.
  always_comb begin
    state_d     = state_q;
    int_pend_d  = int_pend_q;
    int_addr_d  = int_addr_q;
    cnt_d       = cnt_q;
    ctrl_c      = CTRL_NONE;
    jump_flag_c = 1'b0;
    jump_addr_c = '0;
    div_err_c   = 1'b0;

    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (int_assert_i || int_pend_q) begin
            // A fresh request wins over the latched one and carries its own vector.
            ctrl_c      = CTRL_FLUSH_ALL;
            jump_flag_c = 1'b1;
            jump_addr_c = int_assert_i ? int_addr_i : int_addr_q;
            int_pend_d  = 1'b0;
          end else if (ex_jump_flag_i) begin
            ctrl_c      = CTRL_FLUSH_ALL;
            jump_flag_c = 1'b1;
            jump_addr_c = ex_jump_addr_i;
          end else if (ex_div_start_i) begin
            // A single-cycle divide needs no freeze at all.
            if (!div_ready_i) begin
              ctrl_c  = CTRL_HOLD_ALL;
              state_d = ST_DIV_WAIT;
              cnt_d   = CNT_W'(1);
            end
          end else if (load_use_c) begin
            ctrl_c = CTRL_BUBBLE;
          end
        end

        ST_DIV_WAIT: begin
          // Interrupts are only recorded here; the latest vector wins.
          if (int_assert_i) begin
            int_pend_d = 1'b1;
            int_addr_d = int_addr_i;
          end
          if (div_ready_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(DIV_TIMEOUT)) begin
            ctrl_c    = CTRL_WDOG;
            div_err_c = 1'b1;
            state_d   = ST_IDLE;
            cnt_d     = '0;
          end else begin
            ctrl_c = CTRL_HOLD_ALL;
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign hold_pc_o    = ctrl_c.hold_pc;
  assign hold_ifid_o  = ctrl_c.hold_ifid;
  assign hold_idex_o  = ctrl_c.hold_idex;
  assign flush_ifid_o = ctrl_c.flush_ifid;
  assign flush_idex_o = ctrl_c.flush_idex;
  assign jump_flag_o  = jump_flag_c;
  assign jump_addr_o  = jump_addr_c;
  assign div_err_o    = div_err_c;

endmodule
